// File: rtl/dynamic_header_remover_if.sv
// -----------------------------------------------------------------------------
// avalon_st_if
//   Avalon-ST packet interface used by dynamic_header_remover.
//   data  : DATA_W bits, the first byte is in the MSBs
//   valid : beat qualifier
//   sop   : start of packet
//   eop   : end of packet
//   empty : number of invalid bytes at the LSB end; meaningful only on eop
//   rdy   : driven by the sink
// -----------------------------------------------------------------------------
interface avalon_st_if #(
   parameter int DATA_W  = 32,
   parameter int EMPTY_W = 2
);
   logic [DATA_W-1:0]  data;
   logic               valid;
   logic               sop;
   logic               eop;
   logic [EMPTY_W-1:0] empty;
   logic               rdy;

   modport master (output data, valid, sop, eop, empty, input rdy);
   modport slave  (input data, valid, sop, eop, empty, output rdy);
endinterface

// File: rtl/dynamic_header_remover.sv
// -----------------------------------------------------------------------------
// dynamic_header_remover
//   Strips a per-packet, byte-granular header of hdr_len bytes from the front
//   of an Avalon-ST packet, realigns the remaining payload to word boundaries
//   and regenerates sop/eop/empty. Output is registered (1 cycle latency).
//
// Ports
//   clk         : clock
//   rst         : asynchronous, active-high reset
//   msg_in_st   : input packet (slave); rdy is driven here
//   hdr_len     : header bytes to strip, sampled on the accepted sop beat
//   msg_out_st  : stripped packet (master); rdy comes from the sink
//   drop_cnt    : (optional) saturating count of dropped runt packets
//
// Build option
//   DYNAMIC_HEADER_REMOVER_DROP_CNT_EN : adds the drop_cnt output and counter.
// -----------------------------------------------------------------------------
module dynamic_header_remover #(
   parameter int DATA_WIDTH_IN_BYTES = 4,
   parameter int HDR_LEN_WIDTH       = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   avalon_st_if.slave               msg_in_st,
   input  logic [HDR_LEN_WIDTH-1:0] hdr_len,
   avalon_st_if.master              msg_out_st
`ifdef DYNAMIC_HEADER_REMOVER_DROP_CNT_EN
   ,
   output logic [15:0]              drop_cnt
`endif
);
   localparam int W  = DATA_WIDTH_IN_BYTES;
   localparam int DW = W * 8;
   localparam int EW = $clog2(W);

   // FIRST handles the word holding the last header bytes (the first partial word).
   typedef enum logic [2:0] {IDLE, SKIP, FIRST, ALIGN, FLUSH, PASS} state_t;

   state_t                   state_q, state_d;
   logic [HDR_LEN_WIDTH-1:0] skip_q, skip_d;
   logic [EW-1:0]            shift_q, shift_d;
   logic [EW-1:0]            flush_empty_q, flush_empty_d;
   logic [DW-1:0]            carry_q, carry_d;      // left-aligned leftover payload bytes
   logic                     first_out_q, first_out_d;
   logic [DW-1:0]            out_data_q, out_data_d;
   logic                     out_valid_q, out_valid_d;
   logic                     out_sop_q, out_sop_d;
   logic                     out_eop_q, out_eop_d;
   logic [EW-1:0]            out_empty_q, out_empty_d;

   logic                     out_adv;
   logic                     in_rdy;
   logic                     in_fire;
   logic                     runt;
   logic                     do_first;
   logic [HDR_LEN_WIDTH-1:0] hdr_skip;
   logic [DW-1:0]            in_data;
   int                       in_bytes;

   // Output register may load whenever it is empty or being drained.
   assign out_adv  = !out_valid_q || msg_out_st.rdy;
   assign in_rdy   = out_adv && (state_q != FLUSH) && !rst;
   assign in_fire  = msg_in_st.valid && in_rdy;
   assign hdr_skip = hdr_len >> EW;
   assign in_bytes = msg_in_st.eop ? (W - int'(msg_in_st.empty)) : W;
   // Invalid lanes on eop are zeroed so they become the zero pad of the output.
   assign in_data  = msg_in_st.eop ? (msg_in_st.data & ({DW{1'b1}} << (8 * msg_in_st.empty)))
                                   : msg_in_st.data;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d       = state_q;
      skip_d        = skip_q;
      shift_d       = shift_q;
      flush_empty_d = flush_empty_q;
      carry_d       = carry_q;
      first_out_d   = first_out_q;
      out_data_d    = out_data_q;
      out_valid_d   = out_valid_q;
      out_sop_d     = out_sop_q;
      out_eop_d     = out_eop_q;
      out_empty_d   = out_empty_q;
      runt          = 1'b0;
      do_first      = 1'b0;

      if (out_adv) out_valid_d = 1'b0;

      if (state_q == FLUSH) begin
         if (out_adv) begin
            out_valid_d = 1'b1;
            out_sop_d   = 1'b0;
            out_eop_d   = 1'b1;
            out_empty_d = flush_empty_q;
            out_data_d  = carry_q;
            state_d     = IDLE;
         end
      end else if (in_fire) begin
         if (msg_in_st.sop) begin
            // A sop in any state restarts header parsing; a packet in flight is abandoned.
            skip_d      = hdr_skip;
            shift_d     = hdr_len[EW-1:0];
            first_out_d = 1'b0;
            if (hdr_skip != '0) begin
               if (msg_in_st.eop) begin
                  runt = 1'b1;
               end else begin
                  skip_d  = hdr_skip - 1'b1;
                  state_d = (hdr_skip == HDR_LEN_WIDTH'(1)) ? FIRST : SKIP;
               end
            end else begin
               do_first = 1'b1;
            end
         end else begin
            case (state_q)
               SKIP: begin
                  if (msg_in_st.eop) begin
                     runt = 1'b1;
                  end else begin
                     skip_d = skip_q - 1'b1;
                     if (skip_q == HDR_LEN_WIDTH'(1)) state_d = FIRST;
                  end
               end
               FIRST: do_first = 1'b1;
               ALIGN: begin
                  out_valid_d = 1'b1;
                  out_sop_d   = first_out_q;
                  out_data_d  = carry_q | (in_data >> (8 * (W - int'(shift_q))));
                  out_eop_d   = 1'b0;
                  out_empty_d = '0;
                  first_out_d = 1'b0;
                  carry_d     = in_data << (8 * int'(shift_q));
                  if (msg_in_st.eop) begin
                     if (in_bytes <= int'(shift_q)) begin
                        out_eop_d   = 1'b1;
                        out_empty_d = EW'(int'(shift_q) - in_bytes);
                        state_d     = IDLE;
                     end else begin
                        flush_empty_d = EW'(W - in_bytes + int'(shift_q));
                        state_d       = FLUSH;
                     end
                  end
               end
               PASS: begin
                  out_valid_d = 1'b1;
                  out_sop_d   = 1'b0;
                  out_eop_d   = msg_in_st.eop;
                  out_empty_d = msg_in_st.eop ? msg_in_st.empty : '0;
                  out_data_d  = msg_in_st.data;
                  if (msg_in_st.eop) state_d = IDLE;
               end
               default: ;  // stray non-sop beats outside a packet are discarded
            endcase
         end

         if (do_first) begin
            if (shift_d == '0) begin
               out_valid_d = 1'b1;
               out_sop_d   = 1'b1;
               out_eop_d   = msg_in_st.eop;
               out_empty_d = msg_in_st.eop ? msg_in_st.empty : '0;
               out_data_d  = msg_in_st.data;
               state_d     = msg_in_st.eop ? IDLE : PASS;
            end else begin
               carry_d     = in_data << (8 * int'(shift_d));
               first_out_d = 1'b1;
               if (msg_in_st.eop) begin
                  if (in_bytes <= int'(shift_d)) begin
                     runt = 1'b1;
                  end else begin
                     out_valid_d = 1'b1;
                     out_sop_d   = 1'b1;
                     out_eop_d   = 1'b1;
                     out_empty_d = EW'(W - in_bytes + int'(shift_d));
                     out_data_d  = in_data << (8 * int'(shift_d));
                     first_out_d = 1'b0;
                     state_d     = IDLE;
                  end
               end else begin
                  state_d = ALIGN;
               end
            end
         end
      end

      if (runt) state_d = IDLE;
   end

   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together from the values present before the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         skip_q        <= '0;
         shift_q       <= '0;
         flush_empty_q <= '0;
         carry_q       <= '0;
         first_out_q   <= 1'b0;
         out_data_q    <= '0;
         out_valid_q   <= 1'b0;
         out_sop_q     <= 1'b0;
         out_eop_q     <= 1'b0;
         out_empty_q   <= '0;
      end else begin
         state_q       <= state_d;
         skip_q        <= skip_d;
         shift_q       <= shift_d;
         flush_empty_q <= flush_empty_d;
         carry_q       <= carry_d;
         first_out_q   <= first_out_d;
         out_data_q    <= out_data_d;
         out_valid_q   <= out_valid_d;
         out_sop_q     <= out_sop_d;
         out_eop_q     <= out_eop_d;
         out_empty_q   <= out_empty_d;
      end
   end

   assign msg_in_st.rdy    = in_rdy;
   assign msg_out_st.data  = out_data_q;
   assign msg_out_st.valid = out_valid_q;
   assign msg_out_st.sop   = out_sop_q;
   assign msg_out_st.eop   = out_eop_q;
   assign msg_out_st.empty = out_empty_q;

`ifdef DYNAMIC_HEADER_REMOVER_DROP_CNT_EN
   logic [15:0] drop_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                               drop_cnt_q <= '0;
      else if (runt && drop_cnt_q != '1)     drop_cnt_q <= drop_cnt_q + 16'd1;
   end

   assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_dynamic_header_remover.sv
// -----------------------------------------------------------------------------
// tb_dynamic_header_remover
//   Scoreboard bench for dynamic_header_remover (W = 4). A byte-stream model
//   strips the header from each driven packet and queues the expected output
//   beats; a negedge monitor pops and compares each accepted output beat.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dynamic_header_remover;
   typedef struct packed {
      logic        sop;
      logic        eop;
      logic [1:0]  empty;
      logic [31:0] data;
   } beat_t;

   logic       clk;
   logic       rst;
   logic [7:0] hdr_len;
`ifdef DYNAMIC_HEADER_REMOVER_DROP_CNT_EN
   logic [15:0] drop_cnt;
`endif

   avalon_st_if #(.DATA_W(32), .EMPTY_W(2)) in_if ();
   avalon_st_if #(.DATA_W(32), .EMPTY_W(2)) out_if ();

   dynamic_header_remover #(
      .DATA_WIDTH_IN_BYTES (4),
      .HDR_LEN_WIDTH       (8)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .msg_in_st  (in_if),
      .hdr_len    (hdr_len),
      .msg_out_st (out_if)
`ifdef DYNAMIC_HEADER_REMOVER_DROP_CNT_EN
      ,
      .drop_cnt   (drop_cnt)
`endif
   );

   int          n_checks  = 0;
   int          n_fail    = 0;
   int          exp_drops = 0;
   int          rdy_low   = 0;
   logic        cnt_rdy   = 1'b0;
   logic        toggle_en = 1'b0;
   logic        hold_pend = 1'b0;
   beat_t       held;
   beat_t       exp_q[$];
   logic [31:0] pkt_w [8];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Sink ready: constant 1, or toggling every cycle when toggle_en is set.
   always @(posedge clk) begin
      #1;
      out_if.rdy = toggle_en ? ~out_if.rdy : 1'b1;
   end

   // Monitor: a beat with valid & rdy at negedge transfers on the next posedge.
   always @(negedge clk) begin
      beat_t cur;
      beat_t e;
      cur = '{sop: out_if.sop, eop: out_if.eop, empty: out_if.empty, data: out_if.data};
      if (!rst) begin
         if (hold_pend) check("stall_hold", {out_if.valid, cur}, {1'b1, held});
         hold_pend = out_if.valid && !out_if.rdy;
         held      = cur;
         if (out_if.valid && out_if.rdy) begin
            check("sb_has_entry", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               check("out_data", cur.data, e.data);
               check("out_ctrl", {cur.sop, cur.eop, cur.empty}, {e.sop, e.eop, e.empty});
            end
         end
         if (cnt_rdy && !in_if.rdy) rdy_low++;
      end else begin
         hold_pend = 1'b0;
      end
   end

   // Byte-stream reference: concatenate valid bytes, drop h, repack into words.
   task automatic model_pkt(input int h, input int n, input int last_empty);
      byte unsigned b[$];
      beat_t        e;
      logic [31:0]  w;
      logic         first;
      int           nb;
      for (int i = 0; i < n; i++) begin
         w  = pkt_w[i];
         nb = (i == n - 1) ? 4 - last_empty : 4;
         for (int k = 0; k < nb; k++) b.push_back(w[31-8*k -: 8]);
      end
      if (b.size() <= h) begin
         exp_drops++;
         return;
      end
      for (int i = 0; i < h; i++) void'(b.pop_front());
      first = 1'b1;
      while (b.size() != 0) begin
         e     = '0;
         e.sop = first;
         first = 1'b0;
         for (int k = 0; k < 4; k++) begin
            if (b.size() != 0) e.data[31-8*k -: 8] = b.pop_front();
            else               e.empty = e.empty + 2'd1;
         end
         e.eop = (b.size() == 0);
         exp_q.push_back(e);
      end
   endtask

   // Entered and left at posedge+1.
   task automatic drive_beat(input logic [31:0] d, input logic s, input logic e, input logic [1:0] emp);
      int waited = 0;
      in_if.data  = d;
      in_if.sop   = s;
      in_if.eop   = e;
      in_if.empty = emp;
      in_if.valid = 1'b1;
      forever begin
         @(negedge clk);
         if (in_if.rdy) break;
         waited++;
         if (waited > 200) begin
            check("in_rdy_timeout", 64'(waited), 64'd0);
            break;
         end
      end
      @(posedge clk);
      #1;
      in_if.valid = 1'b0;
   endtask

   task automatic send_pkt(input int h, input int n, input int last_empty);
      hdr_len = 8'(h);
      model_pkt(h, n, last_empty);
      for (int i = 0; i < n; i++)
         drive_beat(pkt_w[i], i == 0, i == n - 1, (i == n - 1) ? 2'(last_empty) : 2'd0);
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
      check("drain_empty", 64'(exp_q.size()), 64'd0);
`ifdef DYNAMIC_HEADER_REMOVER_DROP_CNT_EN
      check("drop_cnt", 64'(drop_cnt), 64'(exp_drops));
`endif
      @(posedge clk);
      #1;
   endtask

   task automatic load_ref_pkt(input logic [31:0] last);
      pkt_w[0] = 32'h01234567;
      pkt_w[1] = 32'h89abcdef;
      pkt_w[2] = 32'h18181818;
      pkt_w[3] = last;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int le;
      rst          = 1'b1;
      hdr_len      = '0;
      in_if.valid  = 1'b0;
      in_if.sop    = 1'b0;
      in_if.eop    = 1'b0;
      in_if.empty  = '0;
      in_if.data   = '0;
      out_if.rdy   = 1'b1;
      #3;
      check("rst_out_valid", 64'(out_if.valid), 64'd0);
      check("rst_out_ctrl", {out_if.sop, out_if.eop, out_if.empty}, 64'd0);
      check("rst_out_data", 64'(out_if.data), 64'd0);
      check("rst_in_rdy", 64'(in_if.rdy), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("idle_in_rdy", 64'(in_if.rdy), 64'd1);

      // H = 6: ALIGN then FLUSH; input stalls for exactly the flush cycle.
      load_ref_pkt(32'hf26a0028);
      rdy_low = 0;
      cnt_rdy = 1'b1;
      send_pkt(6, 4, 0);
      drain();
      cnt_rdy = 1'b0;
      check("flush_rdy_low_cycles", 64'(rdy_low), 64'd1);

      // H = 8: whole-word header, PASS path.
      send_pkt(8, 4, 0);
      drain();

      // H = 5, last beat empty 1.
      send_pkt(5, 4, 1);
      drain();

      // H = 16 with a 16-byte packet (runt), then H = 0 passthrough.
      send_pkt(16, 4, 0);
      pkt_w[0] = 32'hdeadbeef;
      pkt_w[1] = 32'h0badf00d;
      send_pkt(0, 2, 0);
      drain();

      // Single-beat packets: one with payload left, one runt in the first word.
      pkt_w[0] = 32'ha1b2c3d4;
      send_pkt(3, 1, 0);
      pkt_w[0] = 32'h55000000;
      send_pkt(1, 1, 3);
      drain();

      // H = 6 with the sink toggling ready.
      load_ref_pkt(32'hf26a0028);
      toggle_en = 1'b1;
      send_pkt(6, 4, 0);
      drain();
      toggle_en = 1'b0;

      // Reset during the second input word of an H = 6 packet.
      load_ref_pkt(32'hf26a0028);
      hdr_len = 8'd6;
      drive_beat(pkt_w[0], 1'b1, 1'b0, 2'd0);
      in_if.data  = pkt_w[1];
      in_if.sop   = 1'b0;
      in_if.eop   = 1'b0;
      in_if.empty = '0;
      in_if.valid = 1'b1;
      #2;
      rst = 1'b1;
      #1;
      check("midrst_out_valid", 64'(out_if.valid), 64'd0);
      check("midrst_out_data", 64'(out_if.data), 64'd0);
      check("midrst_out_ctrl", {out_if.sop, out_if.eop, out_if.empty}, 64'd0);
      check("midrst_in_rdy", 64'(in_if.rdy), 64'd0);
      in_if.valid = 1'b0;
      exp_drops   = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      send_pkt(6, 4, 0);
      drain();

      // Random packets, header lengths and sink behaviour.
      for (int p = 0; p < 8; p++) begin
         n  = $urandom_range(1, 5);
         le = $urandom_range(0, 3);
         for (int i = 0; i < n; i++) pkt_w[i] = $urandom;
         pkt_w[n-1] = pkt_w[n-1] & (32'hffffffff << (8 * le));
         toggle_en  = 1'($urandom_range(0, 1));
         send_pkt($urandom_range(0, 12), n, le);
      end
      drain();
      toggle_en = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dynamic_header_remover.md
Name: dynamic_header_remover

Overview:
- Downstream counterpart of the dynamic header adder: strips a per-packet, byte-granular header from the front of an Avalon-ST packet.
- Realigns the remaining payload to word boundaries and regenerates sop, eop and empty on the output.
- Sits on the receive path after the header has been parsed, so the header length is already known at packet sop.

Parameters:
- DATA_WIDTH_IN_BYTES, 4, stream width W in bytes (W >= 2, power of 2); empty width is log2(W).
- HDR_LEN_WIDTH, 8, width of the header-length input in bytes.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- msg_in_st  avalon_st_if slave  W*8 data  input packet: data, valid, sop, eop, empty; rdy driven by this block.
- hdr_len  in  HDR_LEN_WIDTH  header bytes to strip (H); sampled on the accepted sop beat.
- msg_out_st  avalon_st_if master  W*8 data  stripped packet; rdy driven by the sink.

Behaviour:
- Byte order: first byte in data MSBs; empty counts invalid bytes at the LSB end and is valid only on eop.
- Reset (async, rst=1): state IDLE; out valid/sop/eop = 0; data = 0; empty = 0; carry register = 0; msg_in_st.rdy = 0 while rst=1.
- Handshake:
  - A beat transfers when valid & rdy.
  - msg_in_st.rdy = (!out.valid | out.rdy) & (state != FLUSH).
  - Output is registered. While out.valid & !out.rdy, all output fields hold stable.
- Latency: 1 cycle from accepted input beat to output beat. FLUSH adds 1 beat.
- On the sop beat, latch skip = H / W and shift = H % W. Input bytes per beat: v = W - empty on eop, otherwise v = W.
- States:
  - IDLE: wait for sop. sop with skip > 0 -> SKIP (the sop beat counts as the first dropped word). sop with skip = 0 is handled as the first partial word.
  - SKIP: drop whole words, decrementing skip. When skip reaches 0, the next beat is the first partial word -> ALIGN.
  - First partial word: the top `shift` bytes are header; the low W - shift bytes go into carry; the first_out flag is set.
    - If shift = 0, the word passes through directly (sop on the first output) and the state goes to PASS.
    - If this beat is eop: with payload v - shift <= 0 it is a runt; otherwise emit one beat {payload, zero pad}, sop = eop = 1, empty = W - (v - shift), -> IDLE.
  - ALIGN: each beat emits {carry, top `shift` bytes of input}. sop = first_out, then first_out is cleared; carry <= low W - shift input bytes. On eop:
    - v <= shift: emit carry plus v bytes, eop = 1, empty = shift - v, -> IDLE.
    - v > shift: emit a full word, then -> FLUSH holding v - shift bytes.
  - FLUSH: emit the held bytes with eop = 1 and empty = W - (v - shift), -> IDLE. Input is stalled.
  - PASS: forward beats unchanged (sop only on the first) until eop -> IDLE.
- Runt packet (total bytes <= H, including eop arriving during SKIP): the whole packet is dropped with no output and the block returns to IDLE. H = 0 is plain passthrough.
- sop arriving mid-packet (protocol violation): the current packet is abandoned with no eop, and the new sop is processed from IDLE.
- Reset asserted mid-packet: outputs are cleared immediately and the partial packet is lost.

Optional Feature:
- Macro DYNAMIC_HEADER_REMOVER_DROP_CNT_EN.
- Defined: adds output port drop_cnt (16 bits), a saturating count of runt packets dropped, cleared by rst; it increments the cycle after the runt's eop is accepted.
- Undefined: no port and no counter; runt dropping is otherwise identical.

Test Plan:
- W = 4, H = 6. In: 01234567 (sop), 89abcdef, 18181818, f26a0028 (eop, empty 0). Out: cdef1818 sop, 1818f26a, 00280000 eop empty 2; rdy = 0 for exactly the flush cycle.
- H = 8, same packet. Out: 18181818 sop, f26a0028 eop empty 0 (PASS path).
- H = 5, same words, last beat empty 1. Out: abcdef18 sop, 181818f2, 6a000000 eop empty 2.
- H = 16 with a 16-byte packet, then H = 0 with a 2-word packet. First packet produces no output (drop_cnt = 1 when enabled); second passes through unchanged.
- H = 6 with out.rdy toggled 1010... through the packet. Output sequence identical to the first test; data is stable while stalled; no beat lost or duplicated.
- Assert rst during the second input word of an H = 6 packet. Outputs go to 0 asynchronously; the following packet is processed correctly from IDLE.
